// File: rtl/phase2_pkg.sv
// Shared constants, FSM state type and saturation helpers for the phase2 theta updater.
package phase2_pkg;

  localparam int DW    = 8;
  localparam int N     = 8;
  localparam int ACC_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    UPDATE  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DW-1:0]    DW_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]    DW_MIN   = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [ACC_W:0]   DW_MAX_W = (ACC_W+1)'(2**(DW-1) - 1);
  localparam logic signed [ACC_W:0]   DW_MIN_W = (ACC_W+1)'(-(2**(DW-1)));

  // A one-bit-wider sum overflows ACC_W exactly when its top two bits differ.
  function automatic logic sat_hit_acc(input logic signed [ACC_W:0] v);
    return v[ACC_W] ^ v[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_to_acc(input logic signed [ACC_W:0] v);
    if (!sat_hit_acc(v)) return v[ACC_W-1:0];
    return v[ACC_W] ? ACC_MIN : ACC_MAX;
  endfunction

  function automatic logic sat_hit_dw(input logic signed [ACC_W:0] v);
    return (v > DW_MAX_W) || (v < DW_MIN_W);
  endfunction

  function automatic logic signed [DW-1:0] sat_to_dw(input logic signed [ACC_W:0] v);
    if (v > DW_MAX_W) return DW_MAX;
    if (v < DW_MIN_W) return DW_MIN;
    return v[DW-1:0];
  endfunction

endpackage

// File: rtl/phase2_lane_acc.sv
// One lane: saturating gradient accumulator plus the scaled, saturating theta update.
// Define THETA_UPD_ROUND_EN to round the learning-rate shift half-up instead of flooring.
module phase2_lane_acc
  import phase2_pkg::*;
#(
  parameter int LR_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 acc_en,
  input  logic                 upd_en,
  input  logic                 clr,
  input  logic                 load,
  input  logic signed [DW-1:0] g_lane,
  input  logic signed [DW-1:0] theta_init_lane,
  output logic signed [DW-1:0] theta_lane,
  output logic                 sat
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   acc_wide;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W:0]   acc_sh;
  logic signed [ACC_W:0]   theta_wide;
  logic signed [ACC_W:0]   theta_diff;

`ifdef THETA_UPD_ROUND_EN
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(2**(LR_SHIFT-1));
  logic signed [ACC_W:0] acc_rnd;
`endif

  always_comb begin
    acc_wide   = {acc[ACC_W-1], acc};
    theta_wide = {{(ACC_W+1-DW){theta_lane[DW-1]}}, theta_lane};
    acc_sum    = acc_wide + {{(ACC_W+1-DW){g_lane[DW-1]}}, g_lane};
`ifdef THETA_UPD_ROUND_EN
    acc_rnd    = acc_wide + RND;
    acc_sh     = acc_rnd >>> LR_SHIFT;
`else
    acc_sh     = acc_wide >>> LR_SHIFT;
`endif
    theta_diff = theta_wide - acc_sh;
  end

  assign sat = (acc_en && sat_hit_acc(acc_sum)) || (upd_en && sat_hit_dw(theta_diff));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc        <= '0;
      theta_lane <= '0;
    end else begin
      if (load || clr) acc <= '0;
      else if (acc_en) acc <= sat_to_acc(acc_sum);

      if (load)        theta_lane <= theta_init_lane;
      else if (upd_en) theta_lane <= sat_to_dw(theta_diff);
    end
  end

endmodule

// File: rtl/phase2_theta_update.sv
// Theta updater: accumulates NUM_SAMPLES gradient words, applies theta -= acc >>> LR_SHIFT.
// Rounding of the shift is selected by THETA_UPD_ROUND_EN (see phase2_lane_acc).
module phase2_theta_update
  import phase2_pkg::*;
#(
  parameter int NUM_SAMPLES = 16,
  parameter int CNT_W       = 5,
  parameter int LR_SHIFT    = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic [N*DW-1:0] g,
  input  logic            g_valid,
  output logic            g_ready,
  input  logic [N*DW-1:0] theta_init,
  input  logic            load_init,
  output logic [N*DW-1:0] theta,
  output logic            theta_valid,
  input  logic            theta_ready,
  output logic            busy,
  output logic            sat_flag
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hs;
  logic             last_hs;
  logic             load_go;
  logic             ack_go;
  logic             upd_go;
  logic [N-1:0]     lane_sat;

  assign g_ready     = enable && (state == ACCUM);
  assign hs          = g_valid && g_ready;
  assign last_hs     = hs && (cnt == CNT_W'(NUM_SAMPLES - 1));
  assign load_go     = enable && load_init && ((state == IDLE) || (state == PRESENT));
  // load_init outranks theta_ready when both arrive in PRESENT.
  assign ack_go      = enable && theta_ready && !load_init && (state == PRESENT);
  assign upd_go      = enable && (state == UPDATE);
  assign theta_valid = (state == PRESENT);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if (load_go) begin
      state    <= ACCUM;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (ack_go) begin
        state <= ACCUM;
        cnt   <= '0;
      end
      if (hs) begin
        cnt <= cnt + CNT_W'(1);
        if (last_hs) state <= UPDATE;
      end
      if (upd_go) state <= PRESENT;
      if (|lane_sat) sat_flag <= 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    phase2_lane_acc #(
      .LR_SHIFT(LR_SHIFT)
    ) u_lane (
      .clk            (clk),
      .resetn         (resetn),
      .acc_en         (hs),
      .upd_en         (upd_go),
      .clr            (ack_go),
      .load           (load_go),
      .g_lane         (g[i*DW +: DW]),
      .theta_init_lane(theta_init[i*DW +: DW]),
      .theta_lane     (theta[i*DW +: DW]),
      .sat            (lane_sat[i])
    );
  end

endmodule

// File: tb/tb_phase2_theta_update.sv
// Directed/randomized bench for phase2_theta_update against an arithmetic reference model.
module tb_phase2_theta_update;
  import phase2_pkg::*;

  localparam int NS  = 16;
  localparam int LRS = 4;
`ifdef THETA_UPD_ROUND_EN
  localparam int         RND     = 1 << (LRS - 1);
  localparam logic [7:0] NEG_EXP = 8'h12;
`else
  localparam int         RND     = 0;
  localparam logic [7:0] NEG_EXP = 8'h13;
`endif

  logic            clk = 1'b0;
  logic            resetn, enable, g_valid, load_init, theta_ready;
  logic [N*DW-1:0] g, theta_init, theta;
  logic            g_ready, theta_valid, busy, sat_flag;

  phase2_theta_update #(.NUM_SAMPLES(NS), .CNT_W(5), .LR_SHIFT(LRS)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .g(g), .g_valid(g_valid),
    .g_ready(g_ready), .theta_init(theta_init), .load_init(load_init),
    .theta(theta), .theta_valid(theta_valid), .theta_ready(theta_ready),
    .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          th_m[N];
  int          acc_m[N];
  bit          sat_m;
  logic [63:0] gbuf[NS];
  logic [63:0] snap;
  logic [63:0] init_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int lane_of(input logic [63:0] v, input int i);
    return int'($signed(v[i*DW +: DW]));
  endfunction

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) begin sat_m = 1'b1; return hi; end
    if (v < lo) begin sat_m = 1'b1; return lo; end
    return v;
  endfunction

  function automatic logic [63:0] model_theta();
    logic [63:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(th_m[i]);
    return r;
  endfunction

  task automatic model_clear(input logic [63:0] init);
    for (int i = 0; i < N; i++) begin
      th_m[i]  = lane_of(init, i);
      acc_m[i] = 0;
    end
    sat_m = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] init, input logic with_ready);
    theta_init  = init;
    load_init   = 1'b1;
    theta_ready = with_ready;
    step();
    load_init   = 1'b0;
    theta_ready = 1'b0;
    model_clear(init);
    chk("load_theta", theta, init);
    chk1("load_tvalid", theta_valid, 1'b0);
    chk1("load_gready", g_ready, 1'b1);
    chk1("load_sat", sat_flag, 1'b0);
  endtask

  task automatic send(input logic [63:0] gv);
    g       = gv;
    g_valid = 1'b1;
    #1;
    chk1("send_gready", g_ready, 1'b1);
    step();
    for (int i = 0; i < N; i++) acc_m[i] = clampi(acc_m[i] + lane_of(gv, i), -32768, 32767);
  endtask

  task automatic finish_epoch();
    g_valid = 1'b0;
    chk1("lat_update_tvalid", theta_valid, 1'b0);
    chk1("lat_update_busy", busy, 1'b1);
    step();
    for (int i = 0; i < N; i++)
      th_m[i] = clampi(th_m[i] - floor_div(acc_m[i] + RND, 1 << LRS), -128, 127);
    chk1("lat_present_tvalid", theta_valid, 1'b1);
    chk("epoch_theta", theta, model_theta());
    chk1("epoch_sat", sat_flag, sat_m);
  endtask

  task automatic ack();
    theta_ready = 1'b1;
    step();
    theta_ready = 1'b0;
    for (int i = 0; i < N; i++) acc_m[i] = 0;
    chk1("ack_tvalid", theta_valid, 1'b0);
    chk1("ack_gready", g_ready, 1'b1);
    chk("ack_theta", theta, model_theta());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1; enable = 1'b1; g_valid = 1'b0; load_init = 1'b0;
    theta_ready = 1'b0; g = '0; theta_init = '0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_theta", theta, 64'h0);
    chk1("rst_gready", g_ready, 1'b0);
    chk1("rst_tvalid", theta_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_sat", sat_flag, 1'b0);
    step(); step();
    resetn = 1'b1;
    step();
    chk1("idle_busy", busy, 1'b0);

    // load_init ignored while disabled
    enable = 1'b0; load_init = 1'b1; theta_init = 64'h5555_5555_5555_5555;
    step();
    load_init = 1'b0; enable = 1'b1;
    chk1("dis_load_busy", busy, 1'b0);
    chk("dis_load_theta", theta, 64'h0);

    // basic epoch
    load(64'h1010_1010_1010_1010, 1'b0);
    for (int k = 0; k < NS; k++) send(64'h0202_0202_0202_0202);
    finish_epoch();
    chk("basic_const", theta, 64'h0E0E_0E0E_0E0E_0E0E);

    // backpressure in PRESENT
    snap = theta;
    for (int k = 0; k < 10; k++) begin
      g_valid = k[0];
      g = {$urandom, $urandom};
      step();
      chk1("bp_tvalid", theta_valid, 1'b1);
      chk("bp_theta", theta, snap);
      chk1("bp_gready", g_ready, 1'b0);
    end
    g_valid = 1'b0;
    enable = 1'b0; theta_ready = 1'b1;
    step();
    chk1("dis_ack_tvalid", theta_valid, 1'b1);
    theta_ready = 1'b0; enable = 1'b1;
    ack();

    // enable stall mid-epoch, continuing from current theta
    for (int k = 0; k < NS; k++) gbuf[k] = {$urandom, $urandom};
    for (int k = 0; k < 8; k++) send(gbuf[k]);
    enable = 1'b0; g_valid = 1'b1; g = gbuf[8];
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("stall_gready", g_ready, 1'b0);
    end
    enable = 1'b1;
    for (int k = 8; k < NS; k++) send(gbuf[k]);
    finish_epoch();

    // saturation: load + theta_ready together in PRESENT
    init_v = {$urandom, $urandom};
    init_v[31:24] = 8'h7F;
    load(init_v, 1'b1);
    for (int k = 0; k < NS; k++) begin
      gbuf[k] = {$urandom, $urandom};
      gbuf[k][31:24] = 8'h80;
      send(gbuf[k]);
    end
    finish_epoch();
    snap = theta;
    chk("sat_lane3", {56'h0, snap[31:24]}, 64'h7F);
    chk1("sat_set", sat_flag, 1'b1);
    step();
    chk1("sat_sticky", sat_flag, 1'b1);

    // priority load, then negative/rounding epoch
    init_v = {$urandom, $urandom};
    init_v[7:0] = 8'h10;
    load(init_v, 1'b1);
    for (int k = 0; k < NS; k++) begin
      gbuf[k] = {$urandom, $urandom};
      gbuf[k][7:0] = (k < 8) ? 8'hFE : 8'hFD;
      send(gbuf[k]);
    end
    finish_epoch();
    snap = theta;
    chk("neg_lane0", {56'h0, snap[7:0]}, {56'h0, NEG_EXP});
    ack();

    // reset after 5 handshakes discards the partial epoch
    for (int k = 0; k < 5; k++) send({$urandom, $urandom});
    g_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_theta", theta, 64'h0);
    chk1("mid_rst_gready", g_ready, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_sat", sat_flag, 1'b0);
    model_clear(64'h0);
    step();
    resetn = 1'b1;
    step();
    load({$urandom, $urandom}, 1'b0);
    for (int k = 0; k < NS; k++) send({$urandom, $urandom});
    finish_epoch();
    ack();

    // random epochs with idle gaps and ignored load_init in ACCUM
    for (int e = 0; e < 4; e++) begin
      for (int k = 0; k < NS; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          g_valid = 1'b0;
          load_init = 1'b1;
          theta_init = {$urandom, $urandom};
          g = {$urandom, $urandom};
          step();
          load_init = 1'b0;
        end
        send({$urandom, $urandom});
      end
      finish_epoch();
      ack();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
